// File: rtl/prewish_mask_player_if.sv
// Strobe/data mask handshake between the controller (master) and the LED mask player (slave).
interface prewish_mask_player_if;
   logic       stb;
   logic [7:0] dat;
   logic       ack;

   modport master (output stb, output dat, input ack);
   modport slave  (input stb, input dat, output ack);
endinterface

// File: rtl/prewish_mask_player.sv
// Captures an 8-bit blink mask on a strobe rising edge and plays it MSB first onto one LED,
// one bit per 2^MASK_CLK_BITS clocks, repeating until the next mask arrives.
//
//   state | meaning
//   ------+---------------------------------------------------
//   IDLE  | no pattern (zero mask or after reset), LED off
//   RUN   | prescaler counting, LED follows mask[bit_idx]
module prewish_mask_player #(
   parameter int MASK_CLK_BITS = 20
) (
   input  logic                         CLK_I,
   input  logic                         RST_I,
   prewish_mask_player_if.slave         bus,
   output logic                         o_led,
   output logic                         o_running,
   output logic                         o_wrap
);

   typedef enum logic {IDLE, RUN} state_t;

   localparam logic [MASK_CLK_BITS-1:0] PRESC_ONE = MASK_CLK_BITS'(1);

   state_t                   state_q;
   logic                     stb_prev_q;
   logic [7:0]               mask_q;
   logic [2:0]               bit_idx_q;
   logic [MASK_CLK_BITS-1:0] presc_q;
   logic                     ack_q;
   logic                     led_q;
   logic                     wrap_q;

   logic                     load;
   logic                     tick;
   logic [2:0]               idx_dec;

   always_comb begin
      load    = bus.stb & ~stb_prev_q;
      tick    = (presc_q == '1);
      idx_dec = bit_idx_q - 3'd1;
   end

   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         state_q    <= IDLE;
         stb_prev_q <= 1'b1;   // a strobe already high at release must not load
         mask_q     <= 8'h00;
         bit_idx_q  <= 3'd7;
         presc_q    <= '0;
         ack_q      <= 1'b0;
         led_q      <= 1'b0;
         wrap_q     <= 1'b0;
      end else begin
         stb_prev_q <= bus.stb;
         ack_q      <= 1'b0;
         wrap_q     <= 1'b0;
         if (load) begin
            mask_q    <= bus.dat;
            bit_idx_q <= 3'd7;
            presc_q   <= '0;
            ack_q     <= 1'b1;
            if (bus.dat != 8'h00) begin
               state_q <= RUN;
               led_q   <= bus.dat[7];
            end else begin
               state_q <= IDLE;
               led_q   <= 1'b0;
            end
         end else if (state_q == RUN) begin
            presc_q <= presc_q + PRESC_ONE;
            if (tick) begin
               bit_idx_q <= idx_dec;
               led_q     <= mask_q[idx_dec];
               wrap_q    <= (bit_idx_q == 3'd0);
            end else begin
               led_q <= mask_q[bit_idx_q];
            end
         end else begin
            presc_q <= '0;
            led_q   <= 1'b0;
         end
      end
   end

   assign bus.ack   = ack_q;
   assign o_led     = led_q;
   assign o_running = (state_q == RUN);
   assign o_wrap    = wrap_q;

endmodule

// File: doc/prewish_mask_player.md
# prewish_mask_player

Receiving end of the controller's strobe/data mask interface. Captures an 8-bit blink mask on the rising edge of `STB_I` and plays it, MSB first, onto a single LED output: one bit per mask-clock period, repeating indefinitely until a new mask arrives. It sits between the mentor/controller and the LED pin. It has its own mask-clock prescaler and acknowledges every accepted mask.

## Interface
- `MASK_CLK_BITS`, default 20: prescaler width. Each mask bit is held for 2^MASK_CLK_BITS cycles of `CLK_I`. Legal range 2..26.

- `CLK_I` input, 1 bit: system clock. All state changes on its rising edge.
- `RST_I` input, 1 bit: reset. One clock; reset is synchronous and active-high.
- `STB_I` input, 1 bit: mask strobe. Only its rising edge is significant. It may be held high for any length.
- `DAT_I` input, 8 bits: mask value. Sampled on the cycle the `STB_I` rising edge is detected.
- `ACK_O` output, 1 bit: one-cycle pulse acknowledging an accepted mask.
- `o_led` output, 1 bit: active-high LED drive, registered.
- `o_running` output, 1 bit: high while in the RUN state.
- `o_wrap` output, 1 bit: one-cycle pulse when the pattern wraps from bit 0 back to bit 7.

## Operation
- Registers:
  - `stb_prev` (1 bit)
  - `mask_reg` (8 bits)
  - `bit_idx` (3 bits)
  - `presc` (MASK_CLK_BITS bits)
  - `state` {IDLE, RUN}
  - registered outputs
- Edge detect: `load` = `STB_I` & ~`stb_prev`. `stb_prev` <= `STB_I` every cycle.
  - A long strobe loads exactly once.
  - A strobe must drop for at least 1 cycle before it can load again.
- On `load`, in either state:
  - `mask_reg` <= `DAT_I`, `bit_idx` <= 7, `presc` <= 0, `ACK_O` <= 1.
  - If `DAT_I` != 0: `state` <= RUN and `o_led` <= `DAT_I[7]`.
  - If `DAT_I` == 0: `state` <= IDLE and `o_led` <= 0.
- A load has priority over a prescaler tick in the same cycle. The in-progress phase is discarded.
- IDLE state: `presc` is held at 0, `o_led` = 0, `o_running` = 0, `o_wrap` = 0.
- RUN state, no load: `presc` <= `presc` + 1, modulo 2^MASK_CLK_BITS.
  - Tick occurs when `presc` == all-ones.
  - On a tick, `bit_idx` <= `bit_idx` - 1, modulo 8. This wraps 0 -> 7.
  - On the tick where `bit_idx` goes 0 -> 7, `o_wrap` <= 1 for one cycle.
- `o_led` <= `mask_reg[next bit_idx]`, so the LED always reflects the current bit index with no extra lag.
- `ACK_O` and `o_wrap` are 0 in every cycle they are not explicitly pulsed.

## Timing
- Reset values (cycle after `RST_I` is sampled high):
  - `ACK_O`=0, `o_led`=0, `o_running`=0, `o_wrap`=0
  - `state`=IDLE, `mask_reg`=0, `bit_idx`=7, `presc`=0
- `stb_prev` resets to 1, so a strobe already high at reset release does not load.
- `RST_I` overrides everything, including a simultaneous load. Reset mid-pattern returns to IDLE immediately.
- Load latency: `STB_I` rising at edge t -> `ACK_O`=1, `o_led`=`DAT_I[7]`, `o_running`=1 during cycle t+1. `ACK_O` returns to 0 at t+2.
- Bit period: exactly 2^MASK_CLK_BITS cycles, first bit included. Full pattern: 8 x 2^MASK_CLK_BITS cycles.
- `o_wrap` is high in the same cycle that `o_led` first shows bit 7 again.
- `DAT_I` is sampled only on the load cycle. Changes on any other cycle have no effect.

## Test plan
- Reset with `STB_I`=1 held through release: no `ACK_O` and `o_led`=0 for 100 cycles. Then drop `STB_I` for 1 cycle and raise it with `DAT_I`=8'hA8. Required: `ACK_O` pulses once, then playback starts.
- MASK_CLK_BITS=3, load 8'b10101000: `o_led` sequence is 1,0,1,0,1,0,0,0, each bit exactly 8 cycles. `o_wrap` pulses at cycle 65 after the load, with `o_led`=1 again. Repeat for 3 patterns.
- Long strobe: `STB_I` high for 811 cycles with `DAT_I`=8'hCA. Required: exactly one `ACK_O`. Change `DAT_I` to 8'hFF mid-strobe; playback must still follow 8'hCA.
- Reload mid-bit: load 8'hF0, then load 8'h0F 13 cycles later. Required: `o_led`=0 the cycle after the second load, `presc` restarted, first bit held a full 8 cycles.
- Load 8'h00 while running: `ACK_O` pulses, `o_running`=0, `o_led`=0, and no `o_wrap` for 200 cycles.
- Assert `RST_I` for 1 cycle mid-pattern: all outputs are 0 on the next cycle. A fresh strobe edge afterwards loads normally.
